vector_reverse_stream: RTL and testbench

//   Streaming, parametrised successor to the combinational bit reverser.

---
 rtl/vector_reverse_stream.sv | 136 +++++++++++++
 tb/tb_vector_reverse_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_reverse_stream.sv
// vector_reverse_stream
//   Valid/ready streaming word reorderer. Each accepted beat is reordered by
//   its own in_mode (pass, full bit reverse, group swap, bit reverse within
//   groups) and the result is stored in a two-entry buffer: the output
//   register plus one skid entry. in_ready is derived from registered
//   occupancy only, so there is no combinational out_ready -> in_ready path.
//
//   Handshake: a beat transfers on any rising clk edge where valid && ready.
//   A source holding valid must keep its data stable until ready is seen.
//   The block never withdraws out_valid or changes out_data while stalled.
//
//   Optional feature: define VREV_STATS_EN to add the beat_count output, a
//   16-bit wrapping count of completed output beats.
module vector_reverse_stream #(
    parameter int W   = 16,
    parameter int GRP = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
`ifdef VREV_STATS_EN
    ,
    output logic [15:0]  beat_count
`endif
);

    localparam int NG = W / GRP;

    // Reject group sizes that do not tile the word.
    generate
        if ((W < GRP) || ((W % GRP) != 0)) begin : g_bad_params
            $error("vector_reverse_stream: W (%0d) must be a non-zero multiple of GRP (%0d)", W, GRP);
        end
    endgenerate

    // Occupancy of the two-entry buffer doubles as the control state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t         occ_q;
    occ_t         occ_d;
    logic         push;
    logic         pop;
    logic         load_out_in;
    logic         load_out_skid;
    logic         load_skid;
    logic [W-1:0] in_word;
    logic [W-1:0] skid_data;

    function automatic logic [W-1:0] reorder(input logic [W-1:0] d, input logic [1:0] mode);
        logic [W-1:0] r;
        r = d;
        case (mode)
            2'b01: begin
                for (int i = 0; i < W; i++) r[i] = d[W-1-i];
            end
            2'b10: begin
                for (int g = 0; g < NG; g++)
                    for (int j = 0; j < GRP; j++)
                        r[g*GRP+j] = d[(NG-1-g)*GRP+j];
            end
            2'b11: begin
                for (int g = 0; g < NG; g++)
                    for (int j = 0; j < GRP; j++)
                        r[g*GRP+j] = d[g*GRP+GRP-1-j];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Reordering happens on the way in, so stored words are already final.
    assign in_word = reorder(in_data, in_mode);

    // State register: occupancy, flushed asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) occ_q <= OCC_EMPTY;
        else       occ_q <= occ_d;
    end

    // Next-state: occupancy follows the push/pop combination.
    always_comb begin
        occ_d = occ_q;
        case (occ_q)
            OCC_EMPTY: if (push) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      occ_d = OCC_TWO;
                else if (!push && pop) occ_d = OCC_EMPTY;
            end
            OCC_TWO: if (pop) occ_d = OCC_ONE;
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // Outputs and datapath load enables decoded from occupancy and handshakes.
    always_comb begin
        in_ready      = (occ_q != OCC_TWO);
        out_valid     = (occ_q != OCC_EMPTY);
        push          = in_valid && in_ready;
        pop           = out_valid && out_ready;
        load_out_in   = ((occ_q == OCC_EMPTY) && push) || ((occ_q == OCC_ONE) && push && pop);
        load_out_skid = (occ_q == OCC_TWO) && pop;
        load_skid     = (occ_q == OCC_ONE) && push && !pop;
    end

    // Output register: new word when it can bypass the skid, else promote the skid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              out_data <= '0;
        else if (load_out_in)   out_data <= in_word;
        else if (load_out_skid) out_data <= skid_data;
    end

    // Skid register: captures a beat that arrives while the output is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          skid_data <= '0;
        else if (load_skid) skid_data <= in_word;
    end

`ifdef VREV_STATS_EN
    // Completed-beat counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    beat_count <= 16'h0000;
        else if (pop) beat_count <= beat_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vector_reverse_stream.sv
// tb_vector_reverse_stream
//   Directed bench for vector_reverse_stream at W=16, GRP=8. Expected words
//   are queued when a beat is accepted and compared in order as output beats
//   complete.
module tb_vector_reverse_stream;

    localparam int W   = 16;
    localparam int GRP = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef VREV_STATS_EN
    logic [15:0]  beat_count;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned beats_seen = 0;
    int unsigned stalls = 0;
    int unsigned cyc = 0;

    logic [W-1:0] exp_q[$];

    vector_reverse_stream #(.W(W), .GRP(GRP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef VREV_STATS_EN
        ,
        .beat_count(beat_count)
`endif
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference reorder built from streaming operators.
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] r;
        case (m)
            2'b00:   r = d;
            2'b01:   r = {<<{d}};
            2'b10:   r = {<<GRP{d}};
            default: begin
                r = {<<GRP{d}};
                r = {<<{r}};
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: present a beat, wait (bounded) for acceptance, queue its expected result.
    task automatic send(input logic [W-1:0] d, input logic [1:0] m);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        else           exp_q.push_back(ref_model(d, m));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: a beat completing at the next edge must match the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) check("unexpected_beat", 32'(out_data), 32'hDEAD_BEEF);
            else                   check("beat_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [1:0]  mode;
        int unsigned b0;
        int unsigned c0;
        int unsigned s0;
        logic [W-1:0] d;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Mode coverage with one-cycle latency.
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            send(16'h1234, mode);
            check("mode_latency_valid", 32'(out_valid), 32'd1);
            check("mode_latency_data", 32'(out_data), 32'(ref_model(16'h1234, mode)));
        end
        idle(2);
        check("mode_table_00", 32'(ref_model(16'h1234, 2'b00)), 32'h1234);
        check("mode_table_11", 32'(ref_model(16'h1234, 2'b11)), 32'h482C);
        check("mode_drained", exp_q.size(), 32'd0);

        // Backpressure: two beats fill the buffer, the third is held.
        b0 = beats_seen;
        out_ready = 1'b0;
        send(16'hAAAA, 2'b00);
        send(16'h5555, 2'b00);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h0F0F;
        in_mode  = 2'b00;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'hAAAA);
        end
        out_ready = 1'b1;
        send(16'h0F0F, 2'b00);
        idle(2);
        check("bp_beats", beats_seen - b0, 32'd3);
        check("bp_drained", exp_q.size(), 32'd0);

        // Streaming: back-to-back random beats at full rate.
        b0 = beats_seen;
        c0 = cyc;
        s0 = stalls;
        for (int i = 0; i < 10; i++) begin
            d    = 16'($urandom_range(0, 16'hFFFF));
            mode = 2'($urandom_range(0, 3));
            send(d, mode);
        end
        check("stream_cycles", cyc - c0, 32'd10);
        check("stream_stalls", stalls - s0, 32'd0);
        idle(2);
        check("stream_beats", beats_seen - b0, 32'd10);
        check("stream_drained", exp_q.size(), 32'd0);

        // Reset with both entries occupied.
        out_ready = 1'b0;
        send(16'hC001, 2'b01);
        send(16'hBEEF, 2'b10);
        in_valid = 1'b0;
        check("rst_full_in_ready", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_out_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_after_in_ready", 32'(in_ready), 32'd1);
        check("rst_after_out_valid", 32'(out_valid), 32'd0);
        check("rst_after_out_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        send(16'h1234, 2'b10);
        check("rst_next_data", 32'(out_data), 32'h3412);
        idle(2);
        check("rst_drained", exp_q.size(), 32'd0);

`ifdef VREV_STATS_EN
        // Statistics counter wrap.
        reset = 1'b1;
        #1;
        check("stats_reset", 32'(beat_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) send(16'(i), 2'(i));
        idle(2);
        check("stats_ffff", 32'(beat_count), 32'hFFFF);
        send(16'h00FF, 2'b01);
        idle(2);
        check("stats_wrap0", 32'(beat_count), 32'h0000);
        send(16'hFF00, 2'b11);
        idle(2);
        check("stats_one", 32'(beat_count), 32'h0001);
        #2;
        reset = 1'b1;
        #1;
        check("stats_cleared", 32'(beat_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
